// File: rtl/status_if.sv
// status_if: JTAG USER-chain readback that snapshots a usbclk-domain status word at Capture-DR
// and shifts it out MSB first on tdo. Define STATUS_IF_PARITY_EN to append an even-parity bit.
`timescale 1ns/1ps
module status_if #(
  parameter int DW = 40
) (
  input  logic          usbclk,
  input  logic          rst_n,
  input  logic [DW-1:0] status_data,
  input  logic          drck,
  input  logic          sel,
  input  logic          capture,
  input  logic          shift,
  input  logic          update,
  input  logic          jtag_reset,
  output logic          tdo,
  output logic          snap_strobe,
  output logic          read_done,
  output logic          short_read
);

`ifdef STATUS_IF_PARITY_EN
  localparam int LEN = DW + 1;
`else
  localparam int LEN = DW;
`endif
  localparam logic [7:0] LEN_CNT = 8'(LEN);

  localparam int I_DRCK   = 0;
  localparam int I_SEL    = 1;
  localparam int I_CAP    = 2;
  localparam int I_SHIFT  = 3;
  localparam int I_UPDATE = 4;
  localparam int I_JRST   = 5;

  logic [5:0]     w_jtagIn;
  logic [5:0]     r_sync1;
  logic [5:0]     r_sync2;
  logic [2:0]     r_edge3;
  logic [2:0]     w_rise;
  logic           w_selS;
  logic           w_shiftS;
  logic           w_jrstS;
  logic           w_capEvt;
  logic           w_shiftEvt;
  logic           w_updEvt;
  logic [LEN-1:0] w_load;
  logic [LEN-1:0] r_sr;
  logic [LEN-1:0] w_srNext;
  logic [7:0]     r_cnt;
  logic [7:0]     w_cntNext;
  logic           w_snapNext;
  logic           w_doneNext;
  logic           w_shortNext;
  logic           r_tdo;
  logic           r_snap;
  logic           r_done;
  logic           r_short;

  assign w_jtagIn = {jtag_reset, update, shift, capture, sel, drck};

  // Only drck/capture/update need a third stage; sel, shift and jtag_reset are used as levels.
  always_ff @(posedge usbclk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_edge3 <= '0;
    end else begin
      r_sync1 <= w_jtagIn;
      r_sync2 <= r_sync1;
      r_edge3 <= {r_sync2[I_UPDATE], r_sync2[I_CAP], r_sync2[I_DRCK]};
    end
  end

  assign w_rise     = {r_sync2[I_UPDATE], r_sync2[I_CAP], r_sync2[I_DRCK]} & ~r_edge3;
  assign w_selS     = r_sync2[I_SEL];
  assign w_shiftS   = r_sync2[I_SHIFT];
  assign w_jrstS    = r_sync2[I_JRST];
  assign w_capEvt   = w_rise[1] & w_selS;
  assign w_shiftEvt = w_rise[0] & w_selS & w_shiftS;
  assign w_updEvt   = w_rise[2] & w_selS;

`ifdef STATUS_IF_PARITY_EN
  assign w_load = {status_data, ^status_data};
`else
  assign w_load = status_data;
`endif

  // Priority: jtag_reset, then capture, then shift, then update; losers are dropped.
  always_comb begin
    w_srNext    = r_sr;
    w_cntNext   = r_cnt;
    w_snapNext  = 1'b0;
    w_doneNext  = 1'b0;
    w_shortNext = 1'b0;
    if (w_jrstS) begin
      w_srNext  = '0;
      w_cntNext = '0;
    end else if (w_capEvt) begin
      w_srNext   = w_load;
      w_cntNext  = '0;
      w_snapNext = 1'b1;
    end else if (w_shiftEvt) begin
      w_srNext  = r_sr << 1;
      w_cntNext = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
    end else if (w_updEvt) begin
      if (r_cnt >= LEN_CNT) begin
        w_doneNext = 1'b1;
      end else begin
        w_shortNext = 1'b1;
      end
    end
  end

  always_ff @(posedge usbclk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr    <= '0;
      r_cnt   <= '0;
      r_tdo   <= 1'b0;
      r_snap  <= 1'b0;
      r_done  <= 1'b0;
      r_short <= 1'b0;
    end else begin
      r_sr    <= w_srNext;
      r_cnt   <= w_cntNext;
      r_tdo   <= w_srNext[LEN-1];
      r_snap  <= w_snapNext;
      r_done  <= w_doneNext;
      r_short <= w_shortNext;
    end
  end

  assign tdo         = r_tdo;
  assign snap_strobe = r_snap;
  assign read_done   = r_done;
  assign short_read  = r_short;

endmodule
